sevenseg_scan_driver: RTL and testbench

Consumes the four BCD digits produced by the stopwatch counter chain and drives a 4-digit, common-anode, time-multiplexed seven-segment display. Time is displayed as tens, ones, a decimal point, tenths, hundredths (d3 d2 . d1 d0). The block snapshots the digits once per full scan so a frame never tears. It inserts an all-off gap between digits to suppress ghosting. It sits between the counter and the board's anode and segment pins.

---
 rtl/sseg_pkg.sv | 34 +++
 rtl/sevenseg_scan_driver_if.sv | 18 +
 rtl/bcd_to_sseg.sv | 11 +
 rtl/sevenseg_scan_driver.sv | 100 ++++++++++
 tb/tb_sevenseg_scan_driver.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
//   - state_t     : scan FSM states (GAP = all anodes off, SHOW = one digit lit)
//   - SEG_BLANK   : all segments off (active-low)
//   - SEG_DASH    : only segment g lit, shown for invalid BCD
//   - bcd_to_seg(): BCD digit -> active-low {g,f,e,d,c,b,a}
package sseg_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Digit/display bundle between the stopwatch counter and the scan driver.
//   enb        : display enable (counter side -> driver)
//   d0..d3     : BCD digits hundredths..tens (counter side -> driver)
//   an, seg, dp: active-low anode selects, segments {g..a}, decimal point
// master = counter/board side, slave = the scan driver.
interface sevenseg_scan_driver_if;
    logic       enb;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output enb, d0, d1, d2, d3, input  an, seg, dp);
    modport slave  (input  enb, d0, d1, d2, d3, output an, seg, dp);
endinterface

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder.
//   bcd : 4-bit digit, values 10-15 decode to a dash
//   seg : {g,f,e,d,c,b,a}, active-low
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    assign seg = bcd_to_seg(bcd);
endmodule

// File: rtl/sevenseg_scan_driver.sv
// 4-digit common-anode multiplexed display driver (d3 d2 . d1 d0).
// Each digit is lit for SCAN_DIV cycles, separated by GAP_CYC all-off cycles.
// Digits are snapshotted once per frame so a frame never tears.
//   clk : system clock
//   rst : synchronous active-low reset
//   io  : sevenseg_scan_driver_if.slave (enb, d0..d3 in; an, seg, dp out)
// Build option: SSEG_LZ_BLANK_EN blanks digit 3 when its snapshot is zero.
module sevenseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GAP_CYC  = 1000
) (
    input  logic clk,
    input  logic rst,
    sevenseg_scan_driver_if.slave io
);
    localparam int MAXC = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [PW-1:0] SHOW_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYC - 1);

    state_t          state, nxt_state;
    logic [1:0]      idx, nxt_idx;
    logic [PW-1:0]   phase, nxt_phase;
    logic [3:0][3:0] snap;
    logic            cap_pend;   // first GAP after reset still owes a capture
    logic            cap;
    logic [6:0]      dec_seg;
    logic            lz;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_phase = phase + PW'(1);
        cap       = cap_pend;
        case (state)
            GAP: if (phase == GAP_LAST) begin
                nxt_state = SHOW;
                nxt_phase = '0;
            end
            SHOW: if (phase == SHOW_LAST) begin
                nxt_state = GAP;
                nxt_idx   = idx + 2'd1;
                nxt_phase = '0;
                // entering the gap ahead of digit 0 starts a new frame
                if (idx == 2'd3) cap = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are built from the next state so they land on the same edge.
    bcd_to_sseg u_dec (
        .bcd (snap[nxt_idx]),
        .seg (dec_seg)
    );

`ifdef SSEG_LZ_BLANK_EN
    assign lz = (nxt_idx == 2'd3) && (snap[3] == 4'd0);
`else
    assign lz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= GAP;
            idx      <= 2'd0;
            phase    <= '0;
            snap     <= '0;
            cap_pend <= 1'b1;
            an_q     <= 4'hF;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            phase    <= nxt_phase;
            cap_pend <= 1'b0;
            if (cap) snap <= {io.d3, io.d2, io.d1, io.d0};
            if (nxt_state == SHOW && io.enb) begin
                an_q  <= ~(4'b0001 << nxt_idx);
                seg_q <= lz ? SEG_BLANK : dec_seg;
                dp_q  <= (nxt_idx != 2'd2);
            end else begin
                an_q  <= 4'hF;
                seg_q <= SEG_BLANK;
                dp_q  <= 1'b1;
            end
        end
    end

    assign io.an  = an_q;
    assign io.seg = seg_q;
    assign io.dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
module tb_sevenseg_scan_driver;
    localparam logic [3:0] AOFF = 4'hF;
    localparam logic [6:0] SOFF = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S7 = 7'b1111000, SD = 7'b0111111;
`ifdef SSEG_LZ_BLANK_EN
    localparam logic [6:0] SLZ = SOFF;
`else
    localparam logic [6:0] SLZ = S0;
`endif

    typedef struct {
        logic       rst;
        logic       enb;
        logic [3:0] d3, d2, d1, d0;
        int         ncyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    sevenseg_scan_driver_if sif();

    sevenseg_scan_driver #(.SCAN_DIV(4), .GAP_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (sif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] ean,
                       input logic [6:0] eseg, input logic edp);
        n_chk++;
        if (sif.an !== ean || sif.seg !== eseg || sif.dp !== edp) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, sif.an, sif.seg, sif.dp, ean, eseg, edp);
        end
        n_chk++;
        if ($countones(~sif.an) > 1) begin
            n_fail++;
            $display("FAIL %s onehot: got an=%b, want at most one low", name, sif.an);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [3:0] a3, a2, a1, a0,
                       input int n, input logic [3:0] ean, input logic [6:0] eseg,
                       input logic edp);
        vec_t v;
        v.rst = r; v.enb = e; v.d3 = a3; v.d2 = a2; v.d1 = a1; v.d0 = a0;
        v.ncyc = n; v.an = ean; v.seg = eseg; v.dp = edp;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0;
        sif.enb = 1'b1;
        sif.d3 = 4'd1; sif.d2 = 4'd2; sif.d1 = 4'd3; sif.d0 = 4'd4;

        // reset, then first gap (capture of 1,2,3,4)
        add(0,1, 1,2,3,4, 3, AOFF, SOFF, 1);
        add(1,1, 1,2,3,4, 1, AOFF, SOFF, 1);
        // frame A: 1 2 . 3 4
        add(1,1, 1,2,3,4, 4, 4'b1110, S4, 1);
        add(1,1, 1,2,3,4, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,3,4, 4, 4'b1101, S3, 1);
        add(1,1, 1,2,3,4, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,3,4, 4, 4'b1011, S2, 0);
        add(1,1, 1,2,3,4, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,3,4, 4, 4'b0111, S1, 1);
        add(1,1, 1,2,3,4, 2, AOFF, SOFF, 1);
        // frame B: d1 -> 7 while digit 0 lit, d0 -> C later; frame still old
        add(1,1, 1,2,3,4, 1, 4'b1110, S4, 1);
        add(1,1, 1,2,7,4, 3, 4'b1110, S4, 1);
        add(1,1, 1,2,7,4, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,7,4'hC, 4, 4'b1101, S3, 1);
        add(1,1, 1,2,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,7,4'hC, 4, 4'b1011, S2, 0);
        add(1,1, 1,2,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,7,4'hC, 4, 4'b0111, S1, 1);
        add(1,1, 1,2,7,4'hC, 2, AOFF, SOFF, 1);
        // frame C: new snapshot 1 2 . 7 C
        add(1,1, 1,2,7,4'hC, 4, 4'b1110, SD, 1);
        add(1,1, 1,2,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,7,4'hC, 4, 4'b1101, S7, 1);
        add(1,1, 1,2,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,7,4'hC, 4, 4'b1011, S2, 0);
        add(1,1, 1,2,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 1,2,7,4'hC, 4, 4'b0111, S1, 1);
        add(1,1, 1,2,7,4'hC, 2, AOFF, SOFF, 1);
        // frame D: enb low for 10 cycles, scan keeps its phase
        add(1,0, 1,2,7,4'hC, 10, AOFF, SOFF, 1);
        add(1,1, 1,2,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 0,5,7,4'hC, 4, 4'b1011, S2, 0);
        add(1,1, 0,5,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 0,5,7,4'hC, 4, 4'b0111, S1, 1);
        add(1,1, 0,5,7,4'hC, 2, AOFF, SOFF, 1);
        // frame E: 0 5 . 7 C, leading digit zero
        add(1,1, 0,5,7,4'hC, 4, 4'b1110, SD, 1);
        add(1,1, 0,5,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 0,5,7,4'hC, 4, 4'b1101, S7, 1);
        add(1,1, 0,5,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 0,5,7,4'hC, 4, 4'b1011, S5, 0);
        add(1,1, 0,5,7,4'hC, 2, AOFF, SOFF, 1);
        add(1,1, 0,5,7,4'hC, 4, 4'b0111, SLZ, 1);
        add(1,1, 0,5,7,4'hC, 2, AOFF, SOFF, 1);

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            sif.enb = tbl[i].enb;
            sif.d3 = tbl[i].d3; sif.d2 = tbl[i].d2;
            sif.d1 = tbl[i].d1; sif.d0 = tbl[i].d0;
            for (int c = 0; c < tbl[i].ncyc; c++) begin
                step();
                chk($sformatf("vec%0d cyc%0d", i, c), tbl[i].an, tbl[i].seg, tbl[i].dp);
            end
        end

        // mid-operation reset during digit 2 of frame F
        for (int c = 0; c < 12; c++) step();
        step();
        chk("midrst_pre", 4'b1011, S5, 0);
        rst = 1'b0;
        sif.d3 = 4'd9; sif.d2 = 4'd8; sif.d1 = 4'd6; sif.d0 = 4'd0;
        step();
        chk("midrst_off", AOFF, SOFF, 1);
        rst = 1'b1;
        step();
        chk("midrst_gap", AOFF, SOFF, 1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("midrst_d0 cyc%0d", c), 4'b1110, S0, 1);
        end
        step();
        chk("midrst_gap2", AOFF, SOFF, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
